// File: rtl/gpu_cmd_dispatch.sv
// gpu_cmd_dispatch: single-host command front end for the GPU core array.
// Routes each host command to one core lane, or broadcasts a write to all
// lanes. For a read, it captures the lane's read data after RD_LAT cycles and
// returns that data on the response channel.
module gpu_cmd_dispatch #(
  parameter int N_CORES    = 8,
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 16,
  parameter int CORE_W     = 4,
  parameter int RD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  logic                          host_write,
  input  logic                          host_bcast,
  input  logic [CORE_W-1:0]             host_core,
  input  logic [ADDR_WIDTH-1:0]         host_addr,
  input  logic [DATA_WIDTH-1:0]         host_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [CORE_W-1:0]             rsp_core,
  output logic                          err_pulse,
  output logic [N_CORES-1:0]            core_valid,
  input  logic [N_CORES-1:0]            core_ready,
  output logic                          core_write,
  output logic [ADDR_WIDTH-1:0]         core_addr,
  output logic [DATA_WIDTH-1:0]         core_wdata,
  input  logic [N_CORES*DATA_WIDTH-1:0] core_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CORE_W:0] N_CORES_W = (CORE_W + 1)'(N_CORES);

  state_t                  state_q;
  logic [N_CORES-1:0]      pending_q;
  logic [N_CORES-1:0]      pending_d;
  logic                    host_ready_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic [CORE_W-1:0]       rsp_core_q;
  logic                    err_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [CORE_W-1:0]       sel_q;
  logic [CNT_W-1:0]        rd_cnt_q;

  logic [N_CORES-1:0]      onehot;
  logic                    in_range;
  logic                    is_bcast;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  // Decode the host target, select the read lane, and compute the lanes still pending.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    onehot    = '0;
    sel_rdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      onehot[i] = (host_core == CORE_W'(i));
      if (sel_q == CORE_W'(i)) sel_rdata = core_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
    in_range  = ({1'b0, host_core} < N_CORES_W);
    // A broadcast read is treated as a unicast read of host_core.
    is_bcast  = host_write & host_bcast;
    // Lanes outside pending_q are masked, so their core_ready is ignored.
    pending_d = pending_q & ~core_ready;
  end

  // Command FSM. pending_q doubles as core_valid and is zero outside ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      host_ready_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_core_q   <= '0;
      err_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      rd_cnt_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register updates from pre-edge values.
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host_valid) begin
            write_q <= host_write;
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
            sel_q   <= host_core;
            if (is_bcast) begin
              pending_q    <= {N_CORES{1'b1}};
              host_ready_q <= 1'b0;
              state_q      <= ISSUE;
            end else if (!in_range) begin
              err_q <= 1'b1;
            end else begin
              pending_q    <= onehot;
              host_ready_q <= 1'b0;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          pending_q <= pending_d;
          if (pending_d == '0) begin
            if (write_q) begin
              host_ready_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              rd_cnt_q <= CNT_W'(RD_LAT);
              state_q  <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          rd_cnt_q <= rd_cnt_q - 1'b1;
          if (rd_cnt_q == CNT_W'(1)) begin
            rsp_data_q  <= sel_rdata;
            rsp_core_q  <= sel_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            host_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          pending_q    <= '0;
          host_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign host_ready = host_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_core   = rsp_core_q;
  assign err_pulse  = err_q;
  assign core_valid = pending_q;
  assign core_write = write_q;
  assign core_addr  = addr_q;
  assign core_wdata = wdata_q;

endmodule

// File: tb/tb_gpu_cmd_dispatch.sv
// Self-checking bench for gpu_cmd_dispatch. The main instance has 8 lanes. A
// second instance has 6 lanes so that lanes 6 and 7 fall outside its range.
module tb_gpu_cmd_dispatch;

  localparam int NC = 8;
  localparam int DW = 24;
  localparam int AW = 16;
  localparam int CW = 4;
  localparam int RL = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              host_valid = 1'b0;
  logic              host_write = 1'b0;
  logic              host_bcast = 1'b0;
  logic [CW-1:0]     host_core  = '0;
  logic [AW-1:0]     host_addr  = '0;
  logic [DW-1:0]     host_wdata = '0;
  logic              rsp_ready  = 1'b0;
  logic [NC-1:0]     core_ready = '1;
  logic [NC*DW-1:0]  core_rdata = '0;

  logic              host_ready, rsp_valid, err_pulse, core_write;
  logic [DW-1:0]     rsp_data, core_wdata;
  logic [CW-1:0]     rsp_core;
  logic [NC-1:0]     core_valid;
  logic [AW-1:0]     core_addr;

  logic              host_ready6, rsp_valid6, err_pulse6, core_write6;
  logic [DW-1:0]     rsp_data6, core_wdata6;
  logic [CW-1:0]     rsp_core6;
  logic [5:0]        core_valid6;
  logic [AW-1:0]     core_addr6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpu_cmd_dispatch #(.N_CORES(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CORE_W(CW), .RD_LAT(RL)) u_dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready), .host_write(host_write),
    .host_bcast(host_bcast), .host_core(host_core), .host_addr(host_addr),
    .host_wdata(host_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_core(rsp_core),
    .err_pulse(err_pulse),
    .core_valid(core_valid), .core_ready(core_ready), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata)
  );

  gpu_cmd_dispatch #(.N_CORES(6), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CORE_W(CW), .RD_LAT(RL)) u_dut6 (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready6), .host_write(host_write),
    .host_bcast(host_bcast), .host_core(host_core), .host_addr(host_addr),
    .host_wdata(host_wdata),
    .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready), .rsp_data(rsp_data6), .rsp_core(rsp_core6),
    .err_pulse(err_pulse6),
    .core_valid(core_valid6), .core_ready(core_ready[5:0]), .core_write(core_write6),
    .core_addr(core_addr6), .core_wdata(core_wdata6), .core_rdata(core_rdata[6*DW-1:0])
  );

  typedef struct {
    logic          write;
    logic          bcast;
    logic [CW-1:0] core;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NC-1:0] exp_mask;
    logic          exp_err;
    logic [DW-1:0] exp_rsp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command and return in T1, the cycle after the host handshake.
  task automatic send(input logic w, input logic b, input logic [CW-1:0] c,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (!host_ready && n < 50) begin
      step();
      n++;
    end
    check("host_ready_wait", 32'(host_ready), 32'd1);
    host_valid = 1'b1;
    host_write = w;
    host_bcast = b;
    host_core  = c;
    host_addr  = a;
    host_wdata = d;
    step();
    host_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;

    vecs[0] = '{1'b0, 1'b0, 4'd0,  16'h0100, 24'h000000, 8'h01, 1'b0, 24'hC0DE00};
    vecs[1] = '{1'b0, 1'b0, 4'd1,  16'h0101, 24'h000000, 8'h02, 1'b0, 24'hC0DE01};
    vecs[2] = '{1'b0, 1'b0, 4'd7,  16'h0107, 24'h000000, 8'h80, 1'b0, 24'hC0DE07};
    vecs[3] = '{1'b1, 1'b0, 4'd6,  16'h0200, 24'h0F0F0F, 8'h40, 1'b0, 24'h000000};
    vecs[4] = '{1'b1, 1'b1, 4'd9,  16'h0300, 24'h5A5A5A, 8'hFF, 1'b0, 24'h000000};
    vecs[5] = '{1'b0, 1'b1, 4'd4,  16'h0104, 24'h000000, 8'h10, 1'b0, 24'hC0DE04};
    vecs[6] = '{1'b0, 1'b0, 4'd12, 16'h010C, 24'h000000, 8'h00, 1'b1, 24'h000000};
    vecs[7] = '{1'b1, 1'b0, 4'd8,  16'h0400, 24'h777777, 8'h00, 1'b1, 24'h000000};

    for (int i = 0; i < NC; i++) core_rdata[i*DW +: DW] = 24'hC0DE00 | 24'(i);

    do_reset();
    check("rst_host_ready", 32'(host_ready), 32'd1);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_data",   32'(rsp_data),   32'd0);
    check("rst_core_valid", 32'(core_valid), 32'd0);
    check("rst_err",        32'(err_pulse),  32'd0);
    check("rst_core_addr",  32'(core_addr),  32'd0);
    check("rst_core_write", 32'(core_write), 32'd0);

    // Unicast write to core 3.
    core_ready = '1;
    send(1'b1, 1'b0, 4'd3, 16'h0010, 24'h123456);
    check("uw_valid_t1", 32'(core_valid), 32'h08);
    check("uw_addr",     32'(core_addr),  32'h0010);
    check("uw_wdata",    32'(core_wdata), 32'h123456);
    check("uw_write",    32'(core_write), 32'd1);
    check("uw_hrdy_t1",  32'(host_ready), 32'd0);
    step();
    check("uw_valid_t2", 32'(core_valid), 32'h00);
    check("uw_hrdy_t2",  32'(host_ready), 32'd1);

    // Broadcast write: lanes 0-3 accept at T1, lanes 4-7 accept at T4.
    core_ready = 8'h0F;
    send(1'b1, 1'b1, 4'd0, 16'h0020, 24'hABCDEF);
    check("bw_valid_t1", 32'(core_valid), 32'hFF);
    step();
    check("bw_valid_t2", 32'(core_valid), 32'hF0);
    step();
    check("bw_valid_t3", 32'(core_valid), 32'hF0);
    step();
    check("bw_valid_t4", 32'(core_valid), 32'hF0);
    check("bw_wdata_t4", 32'(core_wdata), 32'hABCDEF);
    check("bw_hrdy_t4",  32'(host_ready), 32'd0);
    core_ready = 8'hFF;
    step();
    check("bw_valid_t5", 32'(core_valid), 32'h00);
    check("bw_hrdy_t5",  32'(host_ready), 32'd1);

    // Read core 5. Lane data is valid only in T3, and the response stalls 3 cycles.
    rsp_ready = 1'b0;
    core_rdata[5*DW +: DW] = 24'h555555;
    send(1'b0, 1'b0, 4'd5, 16'h0050, 24'h000000);
    check("rd_valid_t1", 32'(core_valid), 32'h20);
    check("rd_write_t1", 32'(core_write), 32'd0);
    step();
    check("rd_rsp_t2", 32'(rsp_valid), 32'd0);
    step();
    check("rd_rsp_t3", 32'(rsp_valid), 32'd0);
    core_rdata[5*DW +: DW] = 24'h00BEEF;
    step();
    core_rdata[5*DW +: DW] = 24'h111111;
    check("rd_rsp_t4",  32'(rsp_valid), 32'd1);
    check("rd_data_t4", 32'(rsp_data),  32'h00BEEF);
    check("rd_core_t4", 32'(rsp_core),  32'd5);
    step();
    step();
    check("rd_rsp_t6",  32'(rsp_valid), 32'd1);
    check("rd_data_t6", 32'(rsp_data),  32'h00BEEF);
    step();
    check("rd_rsp_t7",  32'(rsp_valid),  32'd1);
    check("rd_hrdy_t7", 32'(host_ready), 32'd0);
    rsp_ready = 1'b1;
    step();
    check("rd_rsp_t8",  32'(rsp_valid),  32'd0);
    check("rd_hrdy_t8", 32'(host_ready), 32'd1);
    core_rdata[5*DW +: DW] = 24'hC0DE05;

    // Assert reset during RD_WAIT of a read to core 2.
    rsp_ready = 1'b0;
    send(1'b0, 1'b0, 4'd2, 16'h0022, 24'h000000);
    step();
    #2 rst = 1'b1;
    #1;
    check("rw_rst_valid", 32'(core_valid), 32'd0);
    check("rw_rst_hrdy",  32'(host_ready), 32'd1);
    check("rw_rst_rsp",   32'(rsp_valid),  32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    check("rw_no_rsp", 32'(seen), 32'd0);

    // Assert reset during ISSUE: core_valid must drop without waiting for a clock edge.
    core_ready = '0;
    send(1'b1, 1'b0, 4'd1, 16'h0030, 24'h00AAAA);
    check("is_valid", 32'(core_valid), 32'h02);
    #2 rst = 1'b1;
    #1;
    check("is_rst_valid", 32'(core_valid), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    core_ready = '1;
    step();
    check("is_hrdy", 32'(host_ready), 32'd1);

    // Out-of-range unicast write: core 7 on the 6-lane instance.
    send(1'b1, 1'b0, 4'd7, 16'h0070, 24'h0000AA);
    check("oor_err6_t1",   32'(err_pulse6),  32'd1);
    check("oor_valid6_t1", 32'(core_valid6), 32'd0);
    check("oor_hrdy6_t1",  32'(host_ready6), 32'd1);
    check("oor_err8_t1",   32'(err_pulse),   32'd0);
    check("oor_valid8_t1", 32'(core_valid),  32'h80);
    step();
    check("oor_err6_t2", 32'(err_pulse6), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid6 || core_valid6 != 6'd0) seen = 1'b1;
      step();
    end
    check("oor_quiet6", 32'(seen), 32'd0);

    // Table of back-to-back commands with rsp_ready held high.
    rsp_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].write, vecs[v].bcast, vecs[v].core, vecs[v].addr, vecs[v].wdata);
      check($sformatf("v%0d_mask", v), 32'(core_valid), 32'(vecs[v].exp_mask));
      check($sformatf("v%0d_err", v),  32'(err_pulse),  32'(vecs[v].exp_err));
      if (vecs[v].exp_err) begin
        check($sformatf("v%0d_hrdy", v), 32'(host_ready), 32'd1);
      end else begin
        check($sformatf("v%0d_addr", v), 32'(core_addr), 32'(vecs[v].addr));
        if (vecs[v].write) begin
          check($sformatf("v%0d_wdata", v), 32'(core_wdata), 32'(vecs[v].wdata));
          step();
          check($sformatf("v%0d_hrdy", v), 32'(host_ready), 32'd1);
        end else begin
          n = 0;
          while (!rsp_valid && n < 20) begin
            step();
            n++;
          end
          check($sformatf("v%0d_lat", v),   32'(n),        32'(RL + 1));
          check($sformatf("v%0d_data", v),  32'(rsp_data), 32'(vecs[v].exp_rsp));
          check($sformatf("v%0d_core", v),  32'(rsp_core), 32'(vecs[v].core));
          check($sformatf("v%0d_hbusy", v), 32'(host_ready), 32'd0);
          step();
          check($sformatf("v%0d_rspdn", v), 32'(rsp_valid),  32'd0);
          check($sformatf("v%0d_hrdy", v),  32'(host_ready), 32'd1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
